ifetch_buffer: RTL and testbench

Instruction fetch stage directly downstream of the 5-bit program counter in the 16-bit RISC datapath. It samples the PC's fetch address, reads a 32 x 16-bit instruction memory with one-cycle latency, and queues {pc, instr} pairs in a small FIFO. Decode pulls from the FIFO with a valid/ready handshake. A stall output tells the PC to hold when no buffer credit remains, and a flush input discards all fetched and in-flight instructions on a redirect.

---
 rtl/risc16_pkg.sv | 13 +
 rtl/ifetch_buffer_if.sv | 28 ++
 rtl/ifetch_buffer_fetch_fifo.sv | 71 +++++++
 rtl/ifetch_buffer.sv | 77 +++++++
 tb/tb_ifetch_buffer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc16_pkg.sv
// Shared types and widths for the 16-bit RISC datapath.
// The fetch stage queues fetch_entry_t pairs of {pc, instr}.
package risc16_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buffer_if.sv
// Fetch-stage bus: PC request/stall, flush, program loader and decode handshake.
// The master drives requests and consumes entries; the slave is the fetch buffer.
interface ifetch_buffer_if;
  import risc16_pkg::*;

  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_valid;
  logic               pc_stall;
  logic               flush;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output pc_addr, pc_valid, flush, prog_we, prog_addr, prog_data, out_ready,
    input  pc_stall, out_valid, out_instr, out_pc
  );

  modport slave (
    input  pc_addr, pc_valid, flush, prog_we, prog_addr, prog_data, out_ready,
    output pc_stall, out_valid, out_instr, out_pc
  );

endinterface

// File: rtl/ifetch_buffer_fetch_fifo.sv
// First-word-fall-through FIFO of fetch entries; flush clears it in one cycle
// and overrides any push or pop presented in the same cycle.
module fetch_fifo
  import risc16_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr_q] <= push_data;
  end

  assign head  = slots[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch stage: registered-read instruction memory feeding a
// credit-controlled FWFT queue of {pc, instr} entries for decode.
module ifetch_buffer
  import risc16_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  ifetch_buffer_if.slave bus
);

  localparam int CNT_W     = $clog2(DEPTH) + 1;
  localparam int MEM_WORDS = 1 << ADDR_W;

  logic [INSTR_W-1:0] mem [MEM_WORDS];
  logic [INSTR_W-1:0] rdata_q;
  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic               inflight_q, inflight_d;
  logic               issue, push, pop, pc_stall;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_used;
  logic               fifo_empty, fifo_full;
  fetch_entry_t       push_entry, head_entry;

  // Stall looks only at registered state so the PC never sees a combinational
  // path back from its own request, decode's ready or flush.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign pc_stall    = (credit_used >= (CNT_W + 1)'(DEPTH));

  always_comb begin
    issue      = bus.pc_valid && !pc_stall && !bus.flush;
    inflight_d = issue;
    tag_d      = issue ? bus.pc_addr : tag_q;
  end

  assign pop        = !fifo_empty && bus.out_ready;
  assign push       = inflight_q && (!fifo_full || pop);
  assign push_entry = '{pc: tag_q, instr: rdata_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  // Write and read on the same edge: the read register captures the old word.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    if (issue)       rdata_q <= mem[bus.pc_addr];
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.flush),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.pc_stall  = pc_stall;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = fifo_empty ? '0 : head_entry.instr;
  assign bus.out_pc    = fifo_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed and randomised checks of ifetch_buffer: latency, backpressure,
// flush, same-edge memory write, asynchronous reset and a queue-model soak.
module tb_ifetch_buffer;
  import risc16_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [INSTR_W-1:0] exp_mem [32];

  ifetch_buffer_if bus ();

  ifetch_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.pc_valid  = 1'b0;
    bus.pc_addr   = '0;
    bus.flush     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.pc_stall !== 1'b0) begin failures++; $display("FAIL reset_pc_stall: got %0b expected 0", bus.pc_stall); end
    checks++; if (bus.out_instr !== 16'h0000) begin failures++; $display("FAIL reset_out_instr: got %h expected 0000", bus.out_instr); end
    checks++; if (bus.out_pc !== 5'd0) begin failures++; $display("FAIL reset_out_pc: got %0d expected 0", bus.out_pc); end
    // Memory has no reset, so it can be loaded while the pipeline is held.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.prog_we   = 1'b1;
      bus.prog_addr = ADDR_W'(i);
      bus.prog_data = (i < 5) ? 16'(16'h1000 + i) : 16'(i);
      exp_mem[i]    = (i < 5) ? 16'(16'h1000 + i) : 16'(i);
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j >= 2 && j <= 6) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid j=%0d: got %0b expected 1", j, bus.out_valid); end
        checks++; if (bus.out_pc !== ADDR_W'(j - 2)) begin failures++; $display("FAIL stream_pc j=%0d: got %0d expected %0d", j, bus.out_pc, j - 2); end
        checks++; if (bus.out_instr !== exp_mem[j - 2]) begin failures++; $display("FAIL stream_instr j=%0d: got %h expected %h", j, bus.out_instr, exp_mem[j - 2]); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle j=%0d: got %0b expected 0", j, bus.out_valid); end
      end
      checks++; if (bus.pc_stall !== 1'b0) begin failures++; $display("FAIL stream_stall j=%0d: got %0b expected 0", j, bus.pc_stall); end
      bus.pc_valid = (j < 5);
      bus.pc_addr  = ADDR_W'(j);
    end
    bus.pc_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int next_addr = 0;
    int expect_pc = 0;
    int iter = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.pc_valid = 1'b1;
      bus.pc_addr  = ADDR_W'(next_addr);
      if (!bus.pc_stall) next_addr++;
    end
    @(negedge clk);
    checks++; if (next_addr != 4) begin failures++; $display("FAIL bp_accepted: got %0d expected 4", next_addr); end
    checks++; if (bus.pc_stall !== 1'b1) begin failures++; $display("FAIL bp_stall_full: got %0b expected 1", bus.pc_stall); end
    bus.out_ready = 1'b1;
    while (expect_pc < 8 && iter < 40) begin
      if (iter == 1) begin
        checks++; if (bus.pc_stall !== 1'b0) begin failures++; $display("FAIL bp_stall_release: got %0b expected 0", bus.pc_stall); end
      end
      if (bus.out_valid) begin
        checks++; if (bus.out_pc !== ADDR_W'(expect_pc)) begin failures++; $display("FAIL bp_order: got %0d expected %0d", bus.out_pc, expect_pc); end
        checks++; if (bus.out_instr !== exp_mem[expect_pc]) begin failures++; $display("FAIL bp_instr: got %h expected %h", bus.out_instr, exp_mem[expect_pc]); end
        expect_pc++;
      end
      if (next_addr < 8) begin
        bus.pc_valid = 1'b1;
        bus.pc_addr  = ADDR_W'(next_addr);
        if (!bus.pc_stall) next_addr++;
      end else begin
        bus.pc_valid = 1'b0;
      end
      iter++;
      @(negedge clk);
    end
    checks++; if (expect_pc != 8) begin failures++; $display("FAIL bp_drain_timeout: got %0d entries expected 8", expect_pc); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_extra: got %0b expected 0", bus.out_valid); end
    bus.pc_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.pc_valid = 1'b1;
      bus.pc_addr  = ADDR_W'(k);
    end
    @(negedge clk);
    checks++; if (bus.pc_stall !== 1'b1) begin failures++; $display("FAIL flush_pre_stall: got %0b expected 1", bus.pc_stall); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %0b expected 1", bus.out_valid); end
    bus.flush   = 1'b1;
    bus.pc_addr = 5'd10;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.pc_stall !== 1'b0) begin failures++; $display("FAIL flush_stall: got %0b expected 0", bus.pc_stall); end
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_inflight_dropped: got %0b expected 0", bus.out_valid); end
    bus.pc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_refetch_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.out_pc !== 5'd10) begin failures++; $display("FAIL flush_refetch_pc: got %0d expected 10", bus.out_pc); end
    checks++; if (bus.out_instr !== exp_mem[10]) begin failures++; $display("FAIL flush_refetch_instr: got %h expected %h", bus.out_instr, exp_mem[10]); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_after: got %0b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_same_edge_write();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 5'd7;
    bus.prog_data = 16'hBEEF;
    bus.pc_valid  = 1'b1;
    bus.pc_addr   = 5'd7;
    @(negedge clk);
    bus.prog_we  = 1'b0;
    bus.pc_valid = 1'b0;
    exp_mem[7]   = 16'hBEEF;
    @(negedge clk);
    checks++; if (bus.out_pc !== 5'd7) begin failures++; $display("FAIL rw_old_pc: got %0d expected 7", bus.out_pc); end
    checks++; if (bus.out_instr !== 16'h0007) begin failures++; $display("FAIL rw_old_data: got %h expected 0007", bus.out_instr); end
    bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rw_new_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.out_instr !== 16'hBEEF) begin failures++; $display("FAIL rw_new_data: got %h expected beef", bus.out_instr); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset(input int n_fill);
    bus.out_ready = 1'b0;
    for (int k = 0; k < n_fill; k++) begin
      @(negedge clk);
      bus.pc_valid = 1'b1;
      bus.pc_addr  = ADDR_W'(k);
    end
    @(negedge clk);
    bus.pc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid n=%0d: got %0b expected 1", n_fill, bus.out_valid); end
    checks++; if (bus.pc_stall !== (n_fill >= 4)) begin failures++; $display("FAIL arst_pre_stall n=%0d: got %0b expected %0b", n_fill, bus.pc_stall, n_fill >= 4); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid n=%0d: got %0b expected 0", n_fill, bus.out_valid); end
    checks++; if (bus.pc_stall !== 1'b0) begin failures++; $display("FAIL arst_stall n=%0d: got %0b expected 0", n_fill, bus.pc_stall); end
    checks++; if ({bus.out_pc, bus.out_instr} !== 21'd0) begin failures++; $display("FAIL arst_outputs n=%0d: got %h expected 0", n_fill, {bus.out_pc, bus.out_instr}); end
    @(negedge clk);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.pc_valid  = 1'b1;
    bus.pc_addr   = 5'd3;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_no_ghost n=%0d: got %0b expected 0", n_fill, bus.out_valid); end
    bus.pc_addr = 5'd7;
    @(negedge clk);
    bus.pc_valid = 1'b0;
    checks++; if (bus.out_pc !== 5'd3 || bus.out_instr !== exp_mem[3]) begin failures++; $display("FAIL arst_mem3 n=%0d: got pc %0d instr %h expected pc 3 instr %h", n_fill, bus.out_pc, bus.out_instr, exp_mem[3]); end
    @(negedge clk);
    checks++; if (bus.out_pc !== 5'd7 || bus.out_instr !== exp_mem[7]) begin failures++; $display("FAIL arst_mem7 n=%0d: got pc %0d instr %h expected pc 7 instr %h", n_fill, bus.out_pc, bus.out_instr, exp_mem[7]); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_drained n=%0d: got %0b expected 0", n_fill, bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] q[$];
    logic              infl_m = 1'b0;
    logic [ADDR_W-1:0] infl_pc = '0;
    logic              exp_valid, exp_stall, v, r, fl;
    logic [ADDR_W-1:0] a;
    int                ready_pct;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      exp_valid = (q.size() > 0);
      exp_stall = ((q.size() + int'(infl_m)) >= 4);
      checks++; if (bus.out_valid !== exp_valid) begin failures++; $display("FAIL rand_valid c=%0d: got %0b expected %0b", c, bus.out_valid, exp_valid); end
      checks++; if (bus.pc_stall !== exp_stall) begin failures++; $display("FAIL rand_stall c=%0d: got %0b expected %0b", c, bus.pc_stall, exp_stall); end
      if (exp_valid) begin
        checks++; if (bus.out_pc !== q[0] || bus.out_instr !== exp_mem[q[0]]) begin failures++; $display("FAIL rand_head c=%0d: got pc %0d instr %h expected pc %0d instr %h", c, bus.out_pc, bus.out_instr, q[0], exp_mem[q[0]]); end
      end
      if (failures > 40) break;
      ready_pct = ((c / 500) % 2 == 1) ? 90 : 30;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 99) < ready_pct);
      fl = ($urandom_range(0, 49) == 0);
      a  = ADDR_W'($urandom_range(0, 31));
      bus.pc_valid  = v;
      bus.pc_addr   = a;
      bus.out_ready = r;
      bus.flush     = fl;
      if (fl) begin
        q.delete();
        infl_m = 1'b0;
      end else begin
        if (exp_valid && r) void'(q.pop_front());
        if (infl_m) q.push_back(infl_pc);
        infl_m  = v && !exp_stall;
        infl_pc = a;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_same_edge_write();
    test_async_reset(2);
    test_async_reset(4);
    test_random();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
